// File: rtl/ysyx_25020047_wbu_pipe.sv
// Writeback stage: registers one decoded instruction, waits for load data when
// needed, extracts/extends it, and commits one regfile write plus the next PC.
module ysyx_25020047_wbu_pipe #(
    parameter int          XLEN     = 32,
    parameter int          REG_AW   = 5,
    parameter int          CNT_W    = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    localparam int         OFS_W    = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb_sel,
    input  logic              in_npc_sel,
    input  logic [2:0]        in_ld_fmt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_snpc,
    input  logic [OFS_W-1:0]  in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   dnpc,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              ld_misalign,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_e;

    state_e             state_q;
    logic [1:0]         wb_sel_q;
    logic               npc_sel_q;
    logic [2:0]         ld_fmt_q;
    logic [REG_AW-1:0]  rd_q;
    logic [XLEN-1:0]    result_q;
    logic [XLEN-1:0]    snpc_q;
    logic [OFS_W-1:0]   addr_lo_q;
    logic [XLEN-1:0]    wdata_q;
    logic               misalign_q;
    logic [XLEN-1:0]    dnpc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               fire;
    logic               accept;
    logic [XLEN-1:0]    ld_data_d;
    logic               ld_mis_d;
    logic [XLEN-1:0]    alu_wdata_d;

    // Lane views of the aligned memory word, selected by the captured offset.
    logic [7:0]  byte_lane [NB];
    logic [15:0] half_lane [NB/2];
    logic [31:0] word_lane [NB/4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] sel_word;

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign byte_lane[gi] = mem_rdata[8*gi +: 8];
    end
    for (genvar gi = 0; gi < NB/2; gi++) begin : g_half
        assign half_lane[gi] = mem_rdata[16*gi +: 16];
    end
    for (genvar gi = 0; gi < NB/4; gi++) begin : g_word
        assign word_lane[gi] = mem_rdata[32*gi +: 32];
    end

    assign sel_byte = byte_lane[addr_lo_q];
    assign sel_half = half_lane[addr_lo_q[OFS_W-1:1]];

    if (XLEN == 64) begin : g_word_sel64
        assign sel_word = word_lane[addr_lo_q[OFS_W-1]];
    end else begin : g_word_sel32
        assign sel_word = word_lane[0];
    end

    // Illegal formats fold into the misaligned path so they write zero.
    always_comb begin
        ld_mis_d  = 1'b0;
        ld_data_d = '0;
        case (ld_fmt_q)
            3'd0: ld_data_d = XLEN'($signed(sel_byte));
            3'd1: begin
                ld_mis_d  = addr_lo_q[0];
                ld_data_d = XLEN'($signed(sel_half));
            end
            3'd2: begin
                ld_mis_d  = |addr_lo_q[1:0];
                ld_data_d = XLEN'($signed(sel_word));
            end
            3'd3: begin
                ld_mis_d  = (XLEN == 64) ? (|addr_lo_q) : 1'b1;
                ld_data_d = mem_rdata;
            end
            3'd4: ld_data_d = XLEN'(sel_byte);
            3'd5: begin
                ld_mis_d  = addr_lo_q[0];
                ld_data_d = XLEN'(sel_half);
            end
            3'd6: begin
                ld_mis_d  = (XLEN == 64) ? (|addr_lo_q[1:0]) : 1'b1;
                ld_data_d = XLEN'(sel_word);
            end
            default: ld_mis_d = 1'b1;
        endcase
        if (ld_mis_d) begin
            ld_data_d = '0;
        end
    end

    always_comb begin
        alu_wdata_d = '0;
        case (in_wb_sel)
            2'd1:    alu_wdata_d = in_result;
            2'd2:    alu_wdata_d = in_snpc;
            default: alu_wdata_d = '0;
        endcase
    end

    assign out_valid   = (state_q == S_COMMIT);
    assign fire        = out_valid & out_ready;
    assign in_ready    = (state_q == S_IDLE) | fire;
    assign accept      = in_valid & in_ready;

    assign dnpc        = dnpc_q;
    assign rf_waddr    = rd_q;
    assign rf_wdata    = wdata_q;
    assign ld_misalign = out_valid & misalign_q;
    assign retire_cnt  = cnt_q;
    // Held low through reset even if a commit was pending when rst rose.
    assign rf_wen      = fire & ~rst & (wb_sel_q != 2'd0) & (rd_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wb_sel_q   <= 2'd0;
            npc_sel_q  <= 1'b0;
            ld_fmt_q   <= 3'd0;
            rd_q       <= '0;
            result_q   <= '0;
            snpc_q     <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            dnpc_q     <= RESET_PC[XLEN-1:0];
            cnt_q      <= '0;
        end else begin
            if (fire) begin
                cnt_q   <= cnt_q + 1'b1;
                dnpc_q  <= npc_sel_q ? result_q : snpc_q;
                state_q <= S_IDLE;
            end
            if (state_q == S_WAIT_MEM && mem_rvalid) begin
                wdata_q    <= ld_data_d;
                misalign_q <= ld_mis_d;
                state_q    <= S_COMMIT;
            end
            // A same-edge accept replaces the just-committed fields: no bubble.
            if (accept) begin
                wb_sel_q   <= in_wb_sel;
                npc_sel_q  <= in_npc_sel;
                ld_fmt_q   <= in_ld_fmt;
                rd_q       <= in_rd;
                result_q   <= in_result;
                snpc_q     <= in_snpc;
                addr_lo_q  <= in_addr_lo;
                wdata_q    <= alu_wdata_d;
                misalign_q <= 1'b0;
                state_q    <= (in_wb_sel == 2'd3) ? S_WAIT_MEM : S_COMMIT;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_wbu_pipe.sv
// Bench for the writeback stage: directed scenarios plus a random stream, all
// checked per cycle against a single-slot transaction model.
module tb_ysyx_25020047_wbu_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_wb_sel;
    logic              in_npc_sel;
    logic [2:0]        in_ld_fmt;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_result;
    logic [XLEN-1:0]   in_snpc;
    logic [1:0]        in_addr_lo;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   dnpc;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              ld_misalign;
    logic [CNT_W-1:0]  retire_cnt;

    ysyx_25020047_wbu_pipe #(
        .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W), .RESET_PC(64'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_npc_sel(in_npc_sel), .in_ld_fmt(in_ld_fmt),
        .in_rd(in_rd), .in_result(in_result), .in_snpc(in_snpc),
        .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .dnpc(dnpc), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ld_misalign(ld_misalign), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference model: at most one instruction held, with its commit record.
    bit          m_have, m_load, m_got, m_mis;
    logic [1:0]  m_sel;
    logic [4:0]  m_rd;
    logic [2:0]  m_fmt;
    logic [1:0]  m_off;
    logic [31:0] m_wdata, m_npc, m_dnpc;
    int          m_cnt;
    int          dut_writes = 0;
    logic [31:0] last_wdata;
    logic        last_mis;

    function automatic logic exp_mis(input logic [2:0] f, input logic [1:0] o);
        case (f)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return o[0];
            3'd2:       return o != 2'd0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [1:0] o,
                                             input logic [31:0] d);
        logic [31:0] sh, b, h;
        sh = d >> (8 * o);
        b  = sh % 256;
        h  = sh % 65536;
        case (f)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return sh;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic r, input logic iv, input logic [1:0] sel,
                        input logic ns, input logic [2:0] fmt, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] snpc,
                        input logic [1:0] off, input logic ordy, input logic rv,
                        input logic [31:0] rdata);
        bit ready, fire, acc;
        rst = r; in_valid = iv; in_wb_sel = sel; in_npc_sel = ns; in_ld_fmt = fmt;
        in_rd = rd; in_result = res; in_snpc = snpc; in_addr_lo = off;
        out_ready = ordy; mem_rvalid = rv; mem_rdata = rdata;
        #1;
        if (rf_wen === 1'b1) begin
            dut_writes++;
            last_wdata = rf_wdata;
            last_mis   = ld_misalign;
        end
        if (r) begin
            check("wen_in_rst", 64'(rf_wen), 64'd0);
            m_have = 0; m_cnt = 0; m_dnpc = RST_PC;
        end else begin
            ready = m_have && (!m_load || m_got);
            check("out_valid", 64'(out_valid), 64'(ready));
            check("in_ready", 64'(in_ready), 64'(!m_have || (ready && ordy)));
            check("dnpc", 64'(dnpc), 64'(m_dnpc));
            check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
            if (ready) begin
                check("waddr", 64'(rf_waddr), 64'(m_rd));
                if (m_sel != 2'd0) check("wdata", 64'(rf_wdata), 64'(m_wdata));
                check("misalign", 64'(ld_misalign), 64'(m_mis));
                check("rf_wen", 64'(rf_wen), 64'(ordy && m_sel != 2'd0 && m_rd != 5'd0));
            end else begin
                check("rf_wen_idle", 64'(rf_wen), 64'd0);
            end
            fire = ready && ordy;
            acc  = iv && (!m_have || fire);
            if (fire) begin
                m_cnt  = (m_cnt + 1) % 16;
                m_dnpc = m_npc;
                m_have = 0;
            end
            if (m_have && m_load && !m_got && rv) begin
                m_got   = 1;
                m_mis   = exp_mis(m_fmt, m_off);
                m_wdata = m_mis ? 32'd0 : exp_load(m_fmt, m_off, rdata);
            end
            if (acc) begin
                m_have = 1; m_load = (sel == 2'd3); m_got = 0; m_mis = 0;
                m_sel = sel; m_rd = rd; m_fmt = fmt; m_off = off;
                m_npc = ns ? res : snpc;
                m_wdata = (sel == 2'd2) ? snpc : res;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nop(input logic ordy, input logic rv, input logic [31:0] rdata);
        step(0, 0, 2'd0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, ordy, rv, rdata);
    endtask

    task automatic inst(input logic [1:0] sel, input logic ns, input logic [2:0] fmt,
                        input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] snpc, input logic [1:0] off);
        step(0, 1, sel, ns, fmt, rd, res, snpc, off, 1, 0, 32'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 2'd0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1, 0, 32'd0);
        step(1, 0, 2'd0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1, 0, 32'd0);
    endtask

    initial begin
        int w0;
        rst = 1; in_valid = 0; in_wb_sel = 0; in_npc_sel = 0; in_ld_fmt = 0;
        in_rd = 0; in_result = 0; in_snpc = 0; in_addr_lo = 0;
        out_ready = 1; mem_rvalid = 0; mem_rdata = 0;
        m_have = 0; m_load = 0; m_got = 0; m_mis = 0; m_sel = 0; m_rd = 0;
        m_fmt = 0; m_off = 0; m_wdata = 0; m_npc = 0; m_dnpc = RST_PC; m_cnt = 0;
        last_wdata = 0; last_mis = 0;
        @(negedge clk);

        do_reset();
        nop(1, 0, 0);

        inst(2'd1, 0, 3'd0, 5'd5, 32'h1234, 32'h8000_0004, 2'd0);
        nop(1, 0, 0);
        check("addi_wdata", 64'(last_wdata), 64'h1234);
        nop(1, 0, 0);

        w0 = dut_writes;
        for (int i = 0; i < 4; i++)
            inst(2'd1, 0, 3'd0, 5'(i + 1), 32'(i * 3), 32'h8000_0010 + 32'(4 * i), 2'd0);
        nop(1, 0, 0);
        check("b2b_writes", 64'(dut_writes - w0), 64'd4);

        inst(2'd2, 1, 3'd0, 5'd1, 32'h8000_0100, 32'h8000_0008, 2'd0);
        nop(1, 0, 0);
        check("jal_link", 64'(last_wdata), 64'h8000_0008);
        nop(1, 0, 0);
        inst(2'd2, 1, 3'd0, 5'd0, 32'h8000_0200, 32'h8000_0008, 2'd0);
        w0 = dut_writes;
        nop(1, 0, 0);
        check("jal_rd0_nowrite", 64'(dut_writes - w0), 64'd0);
        nop(1, 0, 0);

        for (int f = 0; f < 3; f++) begin
            inst(2'd3, 0, (f == 1) ? 3'd4 : (f == 2) ? 3'd1 : 3'd0, 5'd7,
                 32'h1000, 32'h8000_0020, (f == 2) ? 2'd1 : 2'd2);
            nop(1, 0, 0);
            nop(1, 0, 0);
            nop(1, 1, 32'h0080_0000);
            nop(1, 0, 0);
            if (f == 0) check("lb_data", 64'(last_wdata), 64'hFFFF_FF80);
            if (f == 1) check("lbu_data", 64'(last_wdata), 64'h0000_0080);
            if (f == 2) check("lh_mis", 64'({last_mis, last_wdata}), 64'h1_0000_0000);
        end

        inst(2'd1, 1, 3'd0, 5'd9, 32'h8000_0400, 32'h8000_0030, 2'd0);
        w0 = dut_writes;
        for (int i = 0; i < 5; i++)
            step(0, 1, 2'd1, 0, 3'd0, 5'd3, 32'hdead, 32'hbeef, 2'd0, 0, 0, 32'd0);
        check("bp_nowrite", 64'(dut_writes - w0), 64'd0);
        nop(1, 0, 0);
        check("bp_one_write", 64'(dut_writes - w0), 64'd1);
        nop(1, 0, 0);

        inst(2'd3, 0, 3'd2, 5'd4, 32'h0, 32'h8000_0040, 2'd0);
        nop(1, 0, 0);
        w0 = dut_writes;
        step(1, 0, 2'd0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1, 1, 32'h1111_2222);
        nop(1, 0, 0);
        nop(1, 0, 0);
        check("rst_drop", 64'(dut_writes - w0), 64'd0);

        do_reset();
        w0 = dut_writes;
        for (int i = 0; i < 16; i++)
            inst(2'd1, 0, 3'd0, 5'd2, 32'(i), 32'h8000_0000 + 32'(4 * i), 2'd0);
        nop(1, 0, 0);
        check("wrap_cnt", 64'(retire_cnt), 64'd0);
        check("wrap_writes", 64'(dut_writes - w0), 64'd16);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
